// File: rtl/rect_draw_engine_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rect_draw_engine_pkg
// Brief    : Screen geometry, colour codes and draw FSM encoding shared by the
//            rectangle engine and the game controller.
// Revision : 1.0 - initial release
// ============================================================================
package rect_draw_engine_pkg;

    localparam int SCREEN_W     = 160;
    localparam int SCREEN_H     = 120;
    localparam int COLOUR_BLACK = 0;

    typedef logic [1:0] draw_state_t;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DRAW = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

endpackage
`default_nettype wire

// File: rtl/xy_scan_counter.sv
`default_nettype none
// ============================================================================
// Module   : xy_scan_counter
// Brief    : Raster column/row counter for a w x h block, column fastest,
//            with a flag marking the final pixel of the block.
// Revision : 1.0 - initial release
// ============================================================================
module xy_scan_counter #(
    parameter int X_W = 8,
    parameter int Y_W = 7
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           i_clear,
    input  logic           i_enable,
    input  logic [X_W-1:0] i_w,
    input  logic [Y_W-1:0] i_h,
    output logic [X_W-1:0] o_col,
    output logic [Y_W-1:0] o_row,
    output logic           o_last
);

    logic [X_W-1:0] r_col;
    logic [Y_W-1:0] r_row;
    logic           w_col_wrap;
    logic           w_row_wrap;

    // Only meaningful while i_w and i_h are non-zero.
    assign w_col_wrap = (r_col == (i_w - X_W'(1)));
    assign w_row_wrap = (r_row == (i_h - Y_W'(1)));

    always_ff @(posedge clk) begin
        if (!resetn || i_clear) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_enable) begin
            if (w_col_wrap) begin
                r_col <= '0;
                r_row <= w_row_wrap ? '0 : (r_row + Y_W'(1));
            end else begin
                r_col <= r_col + X_W'(1);
            end
        end
    end

    assign o_col  = r_col;
    assign o_row  = r_row;
    assign o_last = w_col_wrap && w_row_wrap;

endmodule
`default_nettype wire

// File: rtl/rect_draw_engine.sv
`default_nettype none
// ============================================================================
// Module   : rect_draw_engine
// Brief    : Fills a clipped rectangle one pixel per cycle into the VGA
//            adapter write port, with busy/done handshake to the controller.
// Revision : 1.0 - initial release
// ============================================================================
module rect_draw_engine
    import rect_draw_engine_pkg::*;
#(
    parameter int X_W = 8,
    parameter int Y_W = 7,
    parameter int C_W = 3
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           start,
    input  logic           erase,
    input  logic [X_W-1:0] x0,
    input  logic [Y_W-1:0] y0,
    input  logic [X_W-1:0] w,
    input  logic [Y_W-1:0] h,
    input  logic [C_W-1:0] colour_in,
    output logic           busy,
    output logic           done,
    output logic [X_W-1:0] vga_x,
    output logic [Y_W-1:0] vga_y,
    output logic [C_W-1:0] vga_colour,
    output logic           plot
);

    localparam logic [X_W:0]   c_screen_w = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   c_screen_h = (Y_W+1)'(SCREEN_H);
    localparam logic [C_W-1:0] c_black    = C_W'(COLOUR_BLACK);

    draw_state_t    r_state;
    draw_state_t    w_next_state;

    logic [X_W-1:0] r_x0;
    logic [Y_W-1:0] r_y0;
    logic [X_W-1:0] r_w;
    logic [Y_W-1:0] r_h;
    logic           r_erase;
    logic [C_W-1:0] r_colour;

    logic [X_W-1:0] w_col;
    logic [Y_W-1:0] w_row;
    logic           w_last;
    logic           w_zero_size;
    logic [X_W:0]   w_sum_x;
    logic [Y_W:0]   w_sum_y;
    logic           w_on_screen;

    logic           r_busy;
    logic           r_done;
    logic           r_plot;
    logic [X_W-1:0] r_vga_x;
    logic [Y_W-1:0] r_vga_y;
    logic [C_W-1:0] r_vga_colour;

    xy_scan_counter #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_scan (
        .clk      (clk),
        .resetn   (resetn),
        .i_clear  (r_state == ST_LOAD),
        .i_enable (r_state == ST_DRAW),
        .i_w      (r_w),
        .i_h      (r_h),
        .o_col    (w_col),
        .o_row    (w_row),
        .o_last   (w_last)
    );

    assign w_zero_size = (r_w == '0) || (r_h == '0);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = w_zero_size ? ST_DONE : ST_DRAW;
            ST_DRAW: if (w_last) w_next_state = ST_DONE;
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Request is captured once; later input changes never reach the draw.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x0     <= '0;
            r_y0     <= '0;
            r_w      <= '0;
            r_h      <= '0;
            r_erase  <= 1'b0;
            r_colour <= '0;
        end else if ((r_state == ST_IDLE) && start) begin
            r_x0     <= x0;
            r_y0     <= y0;
            r_w      <= w;
            r_h      <= h;
            r_erase  <= erase;
            r_colour <= colour_in;
        end
    end

    // One extra bit keeps the clip test honest when x0+col runs past 2**X_W-1.
    assign w_sum_x     = {1'b0, r_x0} + {1'b0, w_col};
    assign w_sum_y     = {1'b0, r_y0} + {1'b0, w_row};
    assign w_on_screen = (w_sum_x < c_screen_w) && (w_sum_y < c_screen_h);

    // Pixel and done outputs trail the FSM by one cycle, so busy also covers
    // the cycle in which done is presented.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_plot       <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
        end else begin
            r_busy <= (w_next_state != ST_IDLE) || (r_state == ST_DONE);
            r_done <= (r_state == ST_DONE);
            r_plot <= (r_state == ST_DRAW) && w_on_screen;
            if (r_state == ST_DRAW) begin
                r_vga_x      <= w_sum_x[X_W-1:0];
                r_vga_y      <= w_sum_y[Y_W-1:0];
                r_vga_colour <= r_erase ? c_black : r_colour;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign plot       = r_plot;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;

endmodule
`default_nettype wire

// File: tb/tb_rect_draw_engine.sv
`default_nettype none
// Directed bench for rect_draw_engine: raster order, erase, zero size,
// clipping, ignored restart and reset abort.
module tb_rect_draw_engine;

    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    logic           clk       = 1'b0;
    logic           resetn    = 1'b0;
    logic           start     = 1'b0;
    logic           erase     = 1'b0;
    logic [X_W-1:0] x0        = '0;
    logic [Y_W-1:0] y0        = '0;
    logic [X_W-1:0] w         = '0;
    logic [Y_W-1:0] h         = '0;
    logic [C_W-1:0] colour_in = '0;
    logic           busy;
    logic           done;
    logic [X_W-1:0] vga_x;
    logic [Y_W-1:0] vga_y;
    logic [C_W-1:0] vga_colour;
    logic           plot;

    int checks = 0;
    int errors = 0;

    int px[$];
    int py[$];
    int pc[$];
    int pt[$];
    int done_cnt;
    int done_at;
    int busy_cnt;

    rect_draw_engine #(
        .X_W (X_W),
        .Y_W (Y_W),
        .C_W (C_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .erase      (erase),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .colour_in  (colour_in),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .plot       (plot)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic sample(input int n);
        if (plot === 1'b1) begin
            px.push_back(int'(vga_x));
            py.push_back(int'(vga_y));
            pc.push_back(int'(vga_colour));
            pt.push_back(n);
        end
        if (done === 1'b1) begin
            done_cnt++;
            if (done_at < 0) done_at = n;
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    // n counts edges after the start edge; restart_at >= 0 pulses start again
    // (with scrambled inputs) so that it is sampled at edge restart_at+1.
    task automatic run_draw(input int ax0, input int ay0, input int aw, input int ah,
                            input int acol, input int aerase, input int restart_at);
        int n;
        px.delete(); py.delete(); pc.delete(); pt.delete();
        done_cnt = 0;
        done_at  = -1;
        busy_cnt = 0;
        x0        = ax0[X_W-1:0];
        y0        = ay0[Y_W-1:0];
        w         = aw[X_W-1:0];
        h         = ah[Y_W-1:0];
        colour_in = acol[C_W-1:0];
        erase     = aerase[0];
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        n = 0;
        sample(n);
        while (n < 200 && (done_at < 0 || n < done_at + 3)) begin
            if (n == restart_at) begin
                start     = 1'b1;
                x0        = '0;
                y0        = '0;
                w         = 8'd1;
                h         = 7'd1;
                colour_in = 3'd1;
                erase     = ~erase;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            n++;
            sample(n);
        end
        start = 1'b0;
    endtask

    task automatic check_draw(input string tag, input int ax0, input int ay0, input int aw,
                              input int ah, input int acol);
        int k = 0;
        for (int r = 0; r < ah; r++) begin
            for (int c = 0; c < aw; c++) begin
                if ((ax0 + c) < 160 && (ay0 + r) < 120) begin
                    if (k < px.size()) begin
                        check($sformatf("%s_x%0d", tag, k), px[k], ax0 + c);
                        check($sformatf("%s_y%0d", tag, k), py[k], ay0 + r);
                        check($sformatf("%s_col%0d", tag, k), pc[k], acol);
                        check($sformatf("%s_t%0d", tag, k), pt[k], 2 + r * aw + c);
                    end
                    k++;
                end
            end
        end
        check({tag, "_plots"}, px.size(), k);
        check({tag, "_done_at"}, done_at, aw * ah + 2);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_busy_cycles"}, busy_cnt, aw * ah + 3);
    endtask

    initial begin
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", plot, 0);
        check("rst_vga_x", vga_x, 0);
        check("rst_vga_y", vga_y, 0);
        check("rst_vga_colour", vga_colour, 0);
        resetn = 1'b1;
        @(posedge clk); #1;

        // Basic 3x2 fill: 6 pixels, done 8 cycles after start.
        run_draw(10, 20, 3, 2, 5, 0, -1);
        check_draw("basic", 10, 20, 3, 2, 5);

        // Erase ignores colour_in.
        run_draw(30, 40, 4, 1, 7, 1, -1);
        check_draw("erase", 30, 40, 4, 1, 0);

        // Zero width: no plot, busy 3 cycles, done 2 cycles after start.
        run_draw(5, 5, 0, 5, 3, 0, -1);
        check_draw("zero_w", 5, 5, 0, 5, 3);

        // Bottom-right corner: only two on-screen pixels out of 8 cycles.
        run_draw(158, 119, 4, 2, 6, 0, -1);
        check_draw("clip", 158, 119, 4, 2, 6);

        // Restart mid-draw with changed inputs is ignored.
        run_draw(50, 60, 3, 3, 4, 0, 3);
        check_draw("restart", 50, 60, 3, 3, 4);

        // Reset asserted in the 3rd DRAW cycle aborts the draw.
        x0 = 8'd5; y0 = 7'd6; w = 8'd4; h = 7'd2; colour_in = 3'd2; erase = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("abort_plot_n2", plot, 1);
        check("abort_x_n2", vga_x, 5);
        check("abort_y_n2", vga_y, 6);
        @(posedge clk); #1;
        check("abort_plot_n3", plot, 1);
        check("abort_x_n3", vga_x, 6);
        resetn = 1'b0;
        @(posedge clk); #1;
        check("abort_plot_after", plot, 0);
        check("abort_busy_after", busy, 0);
        check("abort_done_after", done, 0);
        resetn = 1'b1;

        // Start on the first edge after release.
        run_draw(20, 30, 2, 2, 6, 0, -1);
        check_draw("after_abort", 20, 30, 2, 2, 6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
